nr_step_apply: RTL and testbench

- Consumes one Newton-Raphson step: a 3x4 single-precision pseudo-inverse invJ, a 4-element residual F(x), and the current 3-element estimate x.
- Computes delta = invJ·F and x_next = x − delta.
- Flags convergence when every |delta[r]| < TOL.
- Sits downstream of the pseudo-inverse stage and feeds x_next back to the Jacobian/residual evaluators.
- Uses one time-multiplexed FP multiply-add unit, sequenced by an FSM, with valid/ready handshakes on both sides.

---
 rtl/nr_step_apply_pkg.sv | 26 ++
 rtl/nr_step_apply_fmac.sv | 116 +++++++++++
 rtl/nr_step_apply.sv | 152 +++++++++++++++
 tb/tb_nr_step_apply.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/nr_step_apply_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nr_step_apply_pkg: shared FP constants, flat-vector element select, FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package nr_step_apply_pkg;

  localparam logic [31:0] FP_ONE     = 32'h3F800000;
  localparam logic [31:0] FP_ZERO    = 32'h00000000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Narrower vectors are zero-extended by the caller.
  function automatic logic [31:0] sel32(input logic [383:0] v, input logic [3:0] k);
    return v[{k, 5'd0} +: 32];
  endfunction

endpackage
`default_nettype wire

// File: rtl/nr_step_apply_fmac.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nr_fmac: result = c +/- round(a*b), round-to-nearest-even, 2-cycle start->done
// Rev 1.0
// ----------------------------------------------------------------------------
module nr_fmac
  import nr_step_apply_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic        neg,
  output logic        done,
  output logic [31:0] result
);

  // Denormal inputs and underflowing results are flushed to signed zero.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [10:0] e,
                                          input logic [22:0] m, input logic g, input logic st);
    logic [33:0]        t;
    logic signed [10:0] ef;
    t  = {e, m} + {33'd0, g & (st | m[0])};
    ef = t[33:23];
    if (ef <= 11'sd0)   return {s, 31'd0};
    if (ef >= 11'sd255) return {s, FP_EXP_MAX, 23'd0};
    return {s, ef[7:0], t[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] fa, input logic [31:0] fb);
    logic               s, za, zb, ia, ib;
    logic [47:0]        ma, mb, p;
    logic signed [10:0] e;
    s  = fa[31] ^ fb[31];
    za = fa[30:23] == 8'd0;
    zb = fb[30:23] == 8'd0;
    ia = fa[30:23] == FP_EXP_MAX;
    ib = fb[30:23] == FP_EXP_MAX;
    if ((ia && fa[22:0] != 23'd0) || (ib && fb[22:0] != 23'd0) || (ia && zb) || (ib && za))
      return FP_QNAN;
    if (ia || ib) return {s, FP_EXP_MAX, 23'd0};
    if (za || zb) return {s, 31'd0};
    ma = {24'd0, 1'b1, fa[22:0]};
    mb = {24'd0, 1'b1, fb[22:0]};
    p  = ma * mb;
    e  = $signed({3'd0, fa[30:23]}) + $signed({3'd0, fb[30:23]}) - 11'sd127;
    if (p[47]) return fp_pack(s, e + 11'sd1, p[46:24], p[23], |p[22:0]);
    return fp_pack(s, e, p[45:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] fa, input logic [31:0] fb);
    logic [31:0]        big, sml;
    logic [7:0]         d;
    logic [26:0]        mb27, ms27, sh, mask;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic signed [10:0] e;
    logic               ia, ib;
    ia = fa[30:23] == FP_EXP_MAX;
    ib = fb[30:23] == FP_EXP_MAX;
    if ((ia && fa[22:0] != 23'd0) || (ib && fb[22:0] != 23'd0) || (ia && ib && fa[31] != fb[31]))
      return FP_QNAN;
    if (ia) return fa;
    if (ib) return fb;
    if (fb[30:0] > fa[30:0]) begin big = fb; sml = fa; end
    else                     begin big = fa; sml = fb; end
    mb27 = (big[30:23] == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'd0};
    ms27 = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'd0};
    d    = big[30:23] - sml[30:23];
    if (d >= 8'd27) begin
      sh = {26'd0, |ms27};
    end else begin
      mask = (27'd1 << d) - 27'd1;
      sh   = (ms27 >> d) | {26'd0, |(ms27 & mask)};
    end
    sum = (big[31] != sml[31]) ? ({1'b0, mb27} - {1'b0, sh}) : ({1'b0, mb27} + {1'b0, sh});
    // Exact cancellation yields +0 except (-0) + (-0).
    if (sum == 28'd0) return {fa[31] & fb[31], 31'd0};
    e = $signed({3'd0, big[30:23]});
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 11'sd1;
    end else begin
      lz = 5'd0;
      for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
      sum = sum << lz;
      e   = e - $signed({6'd0, lz});
    end
    return fp_pack(big[31], e, sum[25:3], sum[2], |sum[1:0]);
  endfunction

  logic [31:0] prod_q, c_q;
  logic        stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= 1'b0;
      done    <= 1'b0;
      prod_q  <= '0;
      c_q     <= '0;
      result  <= '0;
    end else begin
      stage_q <= start;
      done    <= stage_q;
      if (start) begin
        prod_q <= fp_mul(a, b) ^ {neg, 31'd0};
        c_q    <= c;
      end
      if (stage_q) result <= fp_add(prod_q, c_q);
    end
  end

endmodule
`default_nettype wire

// File: rtl/nr_step_apply.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nr_step_apply: delta = invJ*F, x_next = x - delta on one shared fmac, with convergence flag
// Rev 1.0
// ----------------------------------------------------------------------------
module nr_step_apply
  import nr_step_apply_pkg::*;
#(
  parameter logic [31:0] TOL    = 32'h3727C5AC,
  parameter int          ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [383:0]      invj,
  input  logic [127:0]      f,
  input  logic [95:0]       x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [95:0]       delta,
  output logic [95:0]       x_next,
  output logic              converged,
  output logic              err,
  output logic [ITER_W-1:0] iter,
  input  logic              clr_iter
);

  state_t       state_q, state_d;
  logic [383:0] invj_q;
  logic [127:0] f_q;
  logic [95:0]  x_q, dwork_q, xwork_q, xn_new;
  logic [1:0]   row_q, col_q;
  logic [31:0]  acc_q, fm_a, fm_b, fm_c, fm_res;
  logic         busy_q, fm_start, fm_done, fm_neg;
  logic         all_small, any_bad, done_entry;

  nr_fmac u_fmac (
    .clk    (clk),
    .rst    (rst),
    .start  (fm_start),
    .a      (fm_a),
    .b      (fm_b),
    .c      (fm_c),
    .neg    (fm_neg),
    .done   (fm_done),
    .result (fm_res)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fm_start  = 1'b0;
    fm_a      = sel32(invj_q, {row_q, col_q});
    fm_b      = sel32({256'd0, f_q}, {2'd0, col_q});
    fm_c      = acc_q;
    fm_neg    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_MAC;
      end
      S_MAC: begin
        fm_start = !busy_q;
        if (fm_done && col_q == 2'd3) state_d = S_SUB;
      end
      S_SUB: begin
        fm_start = !busy_q;
        fm_a     = sel32({288'd0, dwork_q}, {2'd0, row_q});
        fm_b     = FP_ONE;
        fm_c     = sel32({288'd0, x_q}, {2'd0, row_q});
        fm_neg   = 1'b1;
        if (fm_done) state_d = (row_q == 2'd2) ? S_DONE : S_MAC;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flags are evaluated on the final SUB result so they are ready as DONE is entered.
  always_comb begin
    xn_new = xwork_q;
    xn_new[{row_q, 5'd0} +: 32] = fm_res;
    all_small = 1'b1;
    any_bad   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (dwork_q[32*i +: 31] >= TOL[30:0]) all_small = 1'b0;
      if (dwork_q[32*i+23 +: 8] == FP_EXP_MAX || xn_new[32*i+23 +: 8] == FP_EXP_MAX) any_bad = 1'b1;
    end
  end

  assign done_entry = (state_q == S_SUB) && fm_done && (row_q == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      invj_q    <= '0;
      f_q       <= '0;
      x_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      acc_q     <= FP_ZERO;
      busy_q    <= 1'b0;
      dwork_q   <= '0;
      xwork_q   <= '0;
      delta     <= '0;
      x_next    <= '0;
      converged <= 1'b0;
      err       <= 1'b0;
      iter      <= '0;
    end else begin
      state_q <= state_d;
      if (fm_start)     busy_q <= 1'b1;
      else if (fm_done) busy_q <= 1'b0;
      if (state_q == S_IDLE && in_valid) begin
        invj_q <= invj;
        f_q    <= f;
        x_q    <= x;
        row_q  <= 2'd0;
        col_q  <= 2'd0;
        acc_q  <= FP_ZERO;
      end
      if (state_q == S_MAC && fm_done) begin
        acc_q <= fm_res;
        if (col_q != 2'd3) col_q <= col_q + 2'd1;
        else               dwork_q[{row_q, 5'd0} +: 32] <= fm_res;
      end
      if (state_q == S_SUB && fm_done) begin
        xwork_q <= xn_new;
        if (row_q != 2'd2) begin
          row_q <= row_q + 2'd1;
          col_q <= 2'd0;
          acc_q <= FP_ZERO;
        end
      end
      if (done_entry) begin
        delta     <= dwork_q;
        x_next    <= xn_new;
        err       <= any_bad;
        converged <= all_small && !any_bad;
      end
      if (clr_iter)                        iter <= '0;
      else if (done_entry && iter != '1)   iter <= iter + ITER_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nr_step_apply.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nr_step_apply: directed Newton-step vectors with hand-computed results
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_nr_step_apply;

  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] TWO = 32'h40000000;
  localparam logic [31:0] THR = 32'h40400000;
  localparam logic [31:0] FOU = 32'h40800000;
  localparam logic [31:0] FIV = 32'h40A00000;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, converged, err, clr_iter;
  logic [383:0] invj, ident;
  logic [127:0] f;
  logic [95:0]  x, delta, x_next;
  logic [7:0]   iter;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  nr_step_apply #(.TOL(32'h3727C5AC), .ITER_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .invj      (invj),
    .f         (f),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .delta     (delta),
    .x_next    (x_next),
    .converged (converged),
    .err       (err),
    .iter      (iter),
    .clr_iter  (clr_iter)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_step(input logic [383:0] vj, input logic [127:0] vf, input logic [95:0] vx);
    int n;
    invj = vj; f = vf; x = vx; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_in_ready", {95'd0, in_ready}, 96'd0);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("step_timeout", {95'd0, out_valid}, 96'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [95:0] d, input logic [95:0] xn,
                           input logic cv, input logic er, input logic [7:0] it);
    chk({tag, "_delta"},  delta,             d);
    chk({tag, "_x_next"}, x_next,            xn);
    chk({tag, "_conv"},   {95'd0, converged}, {95'd0, cv});
    chk({tag, "_err"},    {95'd0, err},       {95'd0, er});
    chk({tag, "_iter"},   {88'd0, iter},      {88'd0, it});
  endtask

  initial begin
    ident = '0;
    ident[0*32 +: 32]  = ONE;
    ident[5*32 +: 32]  = ONE;
    ident[10*32 +: 32] = ONE;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_iter = 1'b0;
    invj = '0; f = '0; x = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready",  {95'd0, in_ready},  96'd1);
    chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
    check_res("rst", 96'd0, 96'd0, 1'b0, 1'b0, 8'd0);

    // Identity step, then 5 cycles of backpressure in DONE.
    run_step(ident, {FOU, THR, TWO, ONE}, {FIV, FIV, FIV});
    check_res("ident", {THR, TWO, ONE}, {TWO, THR, FOU}, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {95'd0, out_valid}, 96'd1);
      chk("bp_in_ready",  {95'd0, in_ready},  96'd0);
      check_res("bp", {THR, TWO, ONE}, {TWO, THR, FOU}, 1'b0, 1'b0, 8'd1);
    end
    release_out();
    chk("rel_out_valid", {95'd0, out_valid}, 96'd0);
    chk("rel_in_ready",  {95'd0, in_ready},  96'd1);
    chk("idle_hold_delta", delta, {THR, TWO, ONE});

    run_step(ident, 128'd0, {FIV, FIV, FIV});
    check_res("zero", 96'd0, {FIV, FIV, FIV}, 1'b1, 1'b0, 8'd2);
    release_out();

    run_step(ident, {96'd0, 32'h3727C5AC}, 96'd0);
    check_res("tol_eq", {64'd0, 32'h3727C5AC}, {64'd0, 32'hB727C5AC}, 1'b0, 1'b0, 8'd3);
    release_out();
    run_step(ident, {96'd0, 32'h3727C5AB}, 96'd0);
    check_res("tol_lt", {64'd0, 32'h3727C5AB}, {64'd0, 32'hB727C5AB}, 1'b1, 1'b0, 8'd4);
    release_out();
    run_step(ident, {96'd0, 32'hB727C5AC}, 96'd0);
    check_res("ntol_eq", {64'd0, 32'hB727C5AC}, {64'd0, 32'h3727C5AC}, 1'b0, 1'b0, 8'd5);
    release_out();
    run_step(ident, {96'd0, 32'hB727C5AB}, 96'd0);
    check_res("ntol_lt", {64'd0, 32'hB727C5AB}, {64'd0, 32'h3727C5AB}, 1'b1, 1'b0, 8'd6);
    release_out();

    // Reset lands while the 6th multiply-add is in flight.
    invj = ident; f = {FOU, THR, TWO, ONE}; x = {FIV, FIV, FIV}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("mid_rst_in_ready",  {95'd0, in_ready},  96'd1);
    check_res("mid_rst", 96'd0, 96'd0, 1'b0, 1'b0, 8'd0);

    run_step(ident, {FOU, THR, TWO, ONE}, {FIV, FIV, FIV});
    check_res("post_rst", {THR, TWO, ONE}, {TWO, THR, FOU}, 1'b0, 1'b0, 8'd1);
    release_out();

    run_step(ident, {FOU, THR, TWO, 32'h7FC00000}, {FIV, FIV, FIV});
    chk("nan_err",  {95'd0, err},       96'd1);
    chk("nan_conv", {95'd0, converged}, 96'd0);
    chk("nan_iter", {88'd0, iter},      {88'd0, 8'd2});
    release_out();

    for (int i = 0; i < 253; i++) begin
      run_step(ident, {FOU, THR, TWO, ONE}, {FIV, FIV, FIV});
      release_out();
    end
    chk("iter_255", {88'd0, iter}, {88'd0, 8'hFF});
    run_step(ident, {FOU, THR, TWO, ONE}, {FIV, FIV, FIV});
    chk("iter_sat", {88'd0, iter}, {88'd0, 8'hFF});
    release_out();

    clr_iter = 1'b1;
    @(posedge clk); #1;
    clr_iter = 1'b0;
    chk("clr_iter", {88'd0, iter}, 96'd0);

    // Clear held across the DONE-entry increment: the clear wins.
    clr_iter = 1'b1;
    run_step(ident, {FOU, THR, TWO, ONE}, {FIV, FIV, FIV});
    check_res("clr_win", {THR, TWO, ONE}, {TWO, THR, FOU}, 1'b0, 1'b0, 8'd0);
    release_out();
    clr_iter = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
